// File: rtl/tx_redundant_frame_gen_if.sv
// Control, status and transmit byte-stream signals of the redundant test-frame generator.
`timescale 1ns/1ps
interface tx_redundant_frame_gen_if;
    logic        start;
    logic        adv_data;
    logic [7:0]  redundancy;
    logic [7:0]  segment_number_max;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        busy;
    logic [31:0] frame_count;
    logic [2:0]  dbg_state;

    // Stream contract: tx_data is a frame byte whenever tx_en is high. A new
    // byte (or idle slot) is presented only after a clock edge with adv_data
    // high; on every other edge tx_data/tx_en hold. adv_data is the only pacing.
    modport master (
        output start, adv_data, redundancy, segment_number_max,
        input  tx_data, tx_en, busy, frame_count, dbg_state
    );
    modport slave (
        input  start, adv_data, redundancy, segment_number_max,
        output tx_data, tx_en, busy, frame_count, dbg_state
    );
endinterface

// File: rtl/tx_redundant_frame_gen.sv
// Ethernet II test-frame generator: each segment is sent `redundancy` times back-to-back,
// payload carries copy index and segment number, FCS is CRC-32 over header and payload.
`timescale 1ns/1ps
module tx_redundant_frame_gen #(
    parameter int unsigned PAYLOAD_LEN = 64,
    parameter int unsigned IFG_LEN     = 12,
    parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC     = 48'h00_0A_35_00_00_01,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5
) (
    input logic                     clk125MHz,
    input logic                     RST,
    tx_redundant_frame_gen_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PRE, SFD, HDR, PAY, FCS, IFG} state_t;

    localparam logic [111:0] HDR_BYTES = {DST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [31:0]  CRC_POLY  = 32'hEDB88320;
    localparam logic [15:0]  PAY_LAST  = 16'(PAYLOAD_LEN - 1);
    localparam logic [15:0]  IFG_LAST  = 16'(IFG_LEN - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  tx_data_q, byte_d;
    logic        tx_en_q, en_d;
    logic [31:0] crc_q;
    logic [31:0] frame_count_q;
    logic [15:0] seg_q;
    logic [7:0]  copy_q;
    logic [7:0]  red_q;
    logic [7:0]  seg_max_q;

    logic [7:0]   eff_red, eff_seg_max;
    logic [111:0] hdr_sh;
    logic [31:0]  fcs;
    logic         group_start, frame_last;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

    assign eff_red     = (bus.redundancy == 8'd0) ? 8'd1 : bus.redundancy;
    assign eff_seg_max = (bus.segment_number_max == 8'd0) ? 8'd1 : bus.segment_number_max;

    // (state_q, cnt_q) names the byte currently on tx_data; (state_d, cnt_d) the next one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (bus.start) state_d = PRE;
            end
            PRE: if (cnt_q == 16'd6)  begin state_d = SFD; cnt_d = 16'd0; end
            SFD: begin state_d = HDR; cnt_d = 16'd0; end
            HDR: if (cnt_q == 16'd13) begin state_d = PAY; cnt_d = 16'd0; end
            PAY: if (cnt_q == PAY_LAST) begin state_d = FCS; cnt_d = 16'd0; end
            FCS: if (cnt_q == 16'd3)  begin state_d = IFG; cnt_d = 16'd0; end
            IFG: if (cnt_q == IFG_LAST) begin
                cnt_d   = 16'd0;
                state_d = bus.start ? PRE : IDLE;
            end
            default: begin state_d = IDLE; cnt_d = 16'd0; end
        endcase
    end

    always_comb begin
        hdr_sh = HDR_BYTES << {cnt_d[3:0], 3'b000};
        fcs    = ~crc_q;
        byte_d = 8'h00;
        en_d   = 1'b1;
        case (state_d)
            PRE: byte_d = 8'h55;
            SFD: byte_d = 8'hD5;
            HDR: byte_d = hdr_sh[111:104];
            PAY: begin
                case (cnt_d)
                    16'd0:   byte_d = copy_q;
                    16'd1:   byte_d = seg_q[15:8];
                    16'd2:   byte_d = seg_q[7:0];
                    default: byte_d = seg_q[7:0] + cnt_d[7:0];
                endcase
            end
            FCS: begin
                case (cnt_d[1:0])
                    2'd0:    byte_d = fcs[7:0];
                    2'd1:    byte_d = fcs[15:8];
                    2'd2:    byte_d = fcs[23:16];
                    default: byte_d = fcs[31:24];
                endcase
            end
            default: en_d = 1'b0;
        endcase
    end

    // Settings are latched only when a new segment group begins, so all copies match.
    assign group_start = (state_d == PRE) && (cnt_d == 16'd0) && (copy_q == 8'd0);
    assign frame_last  = (state_d == FCS) && (cnt_d == 16'd3);

    always_ff @(posedge clk125MHz) begin
        if (RST) begin
            state_q       <= IDLE;
            cnt_q         <= 16'd0;
            tx_data_q     <= 8'h00;
            tx_en_q       <= 1'b0;
            crc_q         <= 32'hFFFF_FFFF;
            frame_count_q <= 32'd0;
            seg_q         <= 16'd0;
            copy_q        <= 8'd0;
            red_q         <= 8'd1;
            seg_max_q     <= 8'd1;
        end else if (bus.adv_data) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_data_q <= byte_d;
            tx_en_q   <= en_d;

            if (state_d == PRE)
                crc_q <= 32'hFFFF_FFFF;
            else if (state_d == HDR || state_d == PAY)
                crc_q <= crc_byte(crc_q, byte_d);

            if (group_start) begin
                red_q     <= eff_red;
                seg_max_q <= eff_seg_max;
                if (seg_q >= {8'h00, eff_seg_max}) seg_q <= 16'd0;
            end

            if (frame_last) begin
                frame_count_q <= frame_count_q + 32'd1;
                if (copy_q >= red_q - 8'd1) begin
                    copy_q <= 8'd0;
                    seg_q  <= (seg_q >= {8'h00, seg_max_q} - 16'd1) ? 16'd0 : seg_q + 16'd1;
                end else begin
                    copy_q <= copy_q + 8'd1;
                end
            end
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_en       = tx_en_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.frame_count = frame_count_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_tx_redundant_frame_gen.sv
// Directed bench for tx_redundant_frame_gen: frames captured from tx_data/tx_en and
// compared against frames rebuilt independently from the frame format.
`timescale 1ns/1ps
module tb_tx_redundant_frame_gen;
    localparam logic [111:0] HDR_REF = {48'hFF_FF_FF_FF_FF_FF, 48'h00_0A_35_00_00_01, 16'h88B5};
    localparam int PAY_LEN = 64;

    logic clk125MHz = 1'b0;
    logic RST;

    tx_redundant_frame_gen_if bus();

    tx_redundant_frame_gen dut (
        .clk125MHz (clk125MHz),
        .RST       (RST),
        .bus       (bus)
    );

    always #4 clk125MHz = ~clk125MHz;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int en_cycles = 0;
    int low_run   = 0;
    int gap       = 0;
    int adv_phase = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc32_ref(input int first, input int last);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = first; i <= last; i++) begin
            c = c ^ {24'h0, exp_q[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_exp(input int copy, input int seg);
        logic [31:0] c;
        exp_q = {};
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 14; i++) exp_q.push_back(HDR_REF[8*(13-i) +: 8]);
        for (int k = 0; k < PAY_LEN; k++) begin
            if (k == 0)      exp_q.push_back(8'(copy));
            else if (k == 1) exp_q.push_back(8'(seg >> 8));
            else if (k == 2) exp_q.push_back(8'(seg));
            else             exp_q.push_back(8'((seg + k) % 256));
        end
        c = crc32_ref(8, 85);
        for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    endtask

    task automatic do_reset();
        RST                    = 1'b1;
        bus.start              = 1'b0;
        bus.adv_data           = 1'b1;
        bus.redundancy         = 8'd1;
        bus.segment_number_max = 8'd1;
        adv_phase              = 0;
        repeat (3) @(negedge clk125MHz);
        RST     = 1'b0;
        low_run = 0;
    endtask

    // Steps the clock, driving adv_data with the given period, and collects emitted
    // bytes until tx_en falls after a frame or stop_at bytes are held.
    task automatic run_frame(input int period, input int stop_at, input bit cont);
        bit seen;
        bit last_adv;
        if (!cont) begin
            got_q     = {};
            en_cycles = 0;
        end
        seen     = (got_q.size() > 0);
        last_adv = bus.adv_data;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk125MHz);
            if (bus.tx_en) begin
                if (!seen) gap = low_run;
                seen    = 1'b1;
                low_run = 0;
                en_cycles++;
                if (last_adv) got_q.push_back(bus.tx_data);
            end else begin
                low_run++;
                if (seen) return;
            end
            if (stop_at > 0 && got_q.size() == stop_at) return;
            adv_phase    = (adv_phase + 1) % period;
            bus.adv_data = (adv_phase == 0);
            last_adv     = bus.adv_data;
        end
        check("frame_timeout", 64'd1, 64'd0);
    endtask

    task automatic check_frame(input string tag, input int copy, input int seg);
        int bad;
        int n;
        bad = 0;
        build_exp(copy, seg);
        check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check({tag, "_bad_bytes"}, 64'(bad), 64'd0);
        if (got_q.size() >= 90) begin
            check({tag, "_copy"}, 64'(got_q[22]), 64'(copy));
            check({tag, "_seg"}, 64'(got_q[24]), 64'(seg));
            check({tag, "_fcs"}, {32'h0, got_q[89], got_q[88], got_q[87], got_q[86]},
                  {32'h0, exp_q[89], exp_q[88], exp_q[87], exp_q[86]});
        end
    endtask

    initial begin
        int ifg;
        int stray;
        int copies[8];
        int segs[8];
        copies = '{0, 1, 2, 0, 1, 2, 0, 1};
        segs   = '{0, 0, 0, 1, 1, 1, 0, 0};

        // Reset state
        do_reset();
        check("rst_tx_en", bus.tx_en, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_count", bus.frame_count, 0);
        check("rst_state", bus.dbg_state, 0);

        // Defaults at 1 Gb/s, 1 copy, 1 segment
        bus.start = 1'b1;
        run_frame(1, 0, 0);
        check("t1_first_latency", gap, 0);
        check("t1_en_cycles", en_cycles, 90);
        if (got_q.size() >= 23) begin
            check("t1_byte0", got_q[0], 8'h55);
            check("t1_byte7", got_q[7], 8'hD5);
            check("t1_byte22", got_q[22], 8'h00);
        end
        check_frame("t1_f0", 0, 0);
        check("t1_frame_count", bus.frame_count, 1);
        run_frame(1, 0, 0);
        check("t1_ifg_gap", gap, 12);
        check_frame("t1_f1", 0, 0);
        check("t1_frame_count2", bus.frame_count, 2);

        // Redundancy 3, two segments, eight frames
        do_reset();
        bus.redundancy         = 8'd3;
        bus.segment_number_max = 8'd2;
        bus.start              = 1'b1;
        for (int f = 0; f < 8; f++) begin
            run_frame(1, 0, 0);
            check_frame($sformatf("t2_f%0d", f), copies[f], segs[f]);
            if (got_q.size() >= 26) check($sformatf("t2_pay3_f%0d", f), got_q[25], 8'(segs[f] + 3));
            if (f > 0) check($sformatf("t2_gap_f%0d", f), gap, 12);
        end
        check("t2_frame_count", bus.frame_count, 8);

        // 100 Mb/s pacing: one advance strobe every ten cycles
        do_reset();
        bus.start = 1'b1;
        run_frame(10, 0, 0);
        check("t3_en_cycles", en_cycles, 900);
        check_frame("t3_f0", 0, 0);
        check("t3_frame_count", bus.frame_count, 1);

        // Reset while byte 40 of the second frame is on the wire
        do_reset();
        bus.redundancy         = 8'd3;
        bus.segment_number_max = 8'd2;
        bus.start              = 1'b1;
        run_frame(1, 0, 0);
        check("t4_pre_count", bus.frame_count, 1);
        run_frame(1, 41, 0);
        check("t4_byte40", bus.tx_data, 8'd18);
        RST = 1'b1;
        @(negedge clk125MHz);
        check("t4_tx_en_dropped", bus.tx_en, 0);
        check("t4_frame_count", bus.frame_count, 0);
        check("t4_busy", bus.busy, 0);
        RST     = 1'b0;
        low_run = 0;
        run_frame(1, 0, 0);
        check_frame("t4_after", 0, 0);

        // start dropped mid-payload of copy 1
        do_reset();
        bus.redundancy         = 8'd3;
        bus.segment_number_max = 8'd2;
        bus.start              = 1'b1;
        run_frame(1, 0, 0);
        run_frame(1, 50, 0);
        bus.start = 1'b0;
        run_frame(1, 0, 1);
        check_frame("t5_tail", 1, 0);
        ifg   = 1;
        stray = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk125MHz);
            if (!bus.busy) break;
            if (bus.tx_en) stray++;
            ifg++;
        end
        check("t5_ifg_len", ifg, 12);
        check("t5_busy_idle", bus.busy, 0);
        repeat (20) begin
            @(negedge clk125MHz);
            if (bus.tx_en || bus.busy) stray++;
        end
        check("t5_quiet", stray, 0);
        bus.start = 1'b1;
        run_frame(1, 0, 0);
        check_frame("t5_resume", 2, 0);
        check("t5_frame_count", bus.frame_count, 3);

        // Zero redundancy and zero segment count behave as one
        do_reset();
        bus.redundancy         = 8'd0;
        bus.segment_number_max = 8'd0;
        bus.start              = 1'b1;
        for (int f = 0; f < 3; f++) begin
            run_frame(1, 0, 0);
            check_frame($sformatf("t6_f%0d", f), 0, 0);
        end
        check("t6_frame_count", bus.frame_count, 3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
